exc_ctrl: RTL and testbench

- MEM-stage exception arbiter that feeds the CP0 register file.
- Samples per-instruction exception flags and the interrupt state, picks one exception by priority and issues a single-cycle commit pulse to CP0.
- During commit it flushes the pipeline and redirects the PC to the handler vector, or to EPC for ERET.
- Forwards an in-flight mtc0 to Status/Cause/EPC so interrupt and ERET decisions never use stale CP0 values.

---
 rtl/exc_ctrl.sv | 122 ++++++++++++
 tb/tb_exc_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception arbiter; picks one exception by priority, pulses CP0 commit, flushes and redirects.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ext_int,
    input  logic        stall_i,
    input  logic        valid_m,
    input  logic [31:0] pc_m,
    input  logic        delayslot_m,
    input  logic        adel_if_m,
    input  logic        ri_m,
    input  logic        sys_m,
    input  logic        bp_m,
    input  logic        ov_m,
    input  logic        adel_d_m,
    input  logic        ades_d_m,
    input  logic        eret_m,
    input  logic [31:0] data_addr_m,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic        except_en_o,
    output logic [31:0] except_type_o,
    output logic [31:0] inst_addr_o,
    output logic        delayslot_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);
    typedef enum logic [1:0] {IDLE, COMMIT, HOLD} state_t;
    state_t                      state_q;
    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic                        en_q, flush_q, rv_q, ds_q;
    logic [4:0]                  code_q;
    logic [31:0]                 pc_q, badv_q, rpc_q;
    logic [31:0]                 eff_status, eff_epc, badv;
    logic [1:0]                  eff_sw;
    logic [7:0]                  ip;
    logic [4:0]                  code;
    logic                        int_p, detect, unused;
    // An mtc0 in flight overrides the CP0 read values so decisions never see stale state
    always_comb begin
        eff_status = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : status_i;
        eff_sw     = (cp0_we_i && cp0_waddr_i == 5'd13) ? cp0_wdata_i[9:8] : cause_i[9:8];
        eff_epc    = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
        ip         = {sync_q[SYNC_STAGES-1], eff_sw};
        int_p      = eff_status[0] & ~eff_status[1] & (|(ip & eff_status[15:8]));
        code       = int_p    ? 5'd1  : adel_if_m ? 5'd4  : ri_m     ? 5'd10 :
                     sys_m    ? 5'd8  : bp_m      ? 5'd9  : ov_m     ? 5'd12 :
                     adel_d_m ? 5'd4  : ades_d_m  ? 5'd5  : eret_m   ? 5'd14 : 5'd0;
        badv       = (!int_p && adel_if_m) ? pc_m :
                     (code == 5'd4 || code == 5'd5) ? data_addr_m : 32'd0;
        detect     = valid_m && state_q == IDLE && code != 5'd0;
        unused     = ^{eff_status[31:16], eff_status[7:2], cause_i[31:10], cause_i[7:0]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= ext_int;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            flush_q <= 1'b0;
            rv_q    <= 1'b0;
            ds_q    <= 1'b0;
            code_q  <= '0;
            pc_q    <= '0;
            badv_q  <= '0;
            rpc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (detect) begin
                    state_q <= COMMIT;
                    en_q    <= 1'b1;
                    flush_q <= 1'b1;
                    rv_q    <= 1'b1;
                    ds_q    <= delayslot_m;
                    code_q  <= code;
                    pc_q    <= pc_m;
                    badv_q  <= badv;
                    rpc_q   <= (code == 5'd14) ? eff_epc : EXC_VECTOR;
                end
                COMMIT, HOLD: begin
                    en_q <= 1'b0;
                    if (stall_i) begin
                        state_q <= HOLD;
                    end else begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        rv_q    <= 1'b0;
                        ds_q    <= 1'b0;
                        code_q  <= '0;
                        pc_q    <= '0;
                        badv_q  <= '0;
                        rpc_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign except_en_o      = en_q;
    assign except_type_o    = {27'd0, code_q};
    assign inst_addr_o      = pc_q;
    assign delayslot_o      = ds_q;
    assign badvaddr_o       = badv_q;
    assign flush_o          = flush_q;
    assign redirect_valid_o = rv_q;
    assign redirect_pc_o    = rpc_q;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed scenarios plus randomized run against a priority-list reference model.
`timescale 1ns/1ps
module tb_exc_ctrl;
    localparam int          S   = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;
    logic        clk = 0, rst = 1;
    logic [5:0]  ext_int;
    logic        stall_i, valid_m, delayslot_m, adel_if_m, ri_m, sys_m, bp_m, ov_m, adel_d_m, ades_d_m, eret_m;
    logic [31:0] pc_m, data_addr_m, status_i, cause_i, epc_i, cp0_wdata_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic        except_en_o, delayslot_o, flush_o, redirect_valid_o;
    logic [31:0] except_type_o, inst_addr_o, badvaddr_o, redirect_pc_o;
    int checks = 0, errors = 0;

    exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .ext_int(ext_int), .stall_i(stall_i), .valid_m(valid_m),
        .pc_m(pc_m), .delayslot_m(delayslot_m), .adel_if_m(adel_if_m), .ri_m(ri_m),
        .sys_m(sys_m), .bp_m(bp_m), .ov_m(ov_m), .adel_d_m(adel_d_m), .ades_d_m(ades_d_m),
        .eret_m(eret_m), .data_addr_m(data_addr_m), .status_i(status_i), .cause_i(cause_i),
        .epc_i(epc_i), .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
        .except_en_o(except_en_o), .except_type_o(except_type_o), .inst_addr_o(inst_addr_o),
        .delayslot_o(delayslot_o), .badvaddr_o(badvaddr_o), .flush_o(flush_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        ext_int = 0; stall_i = 0; valid_m = 0; pc_m = 0; delayslot_m = 0;
        adel_if_m = 0; ri_m = 0; sys_m = 0; bp_m = 0; ov_m = 0; adel_d_m = 0; ades_d_m = 0; eret_m = 0;
        data_addr_m = 0; status_i = 0; cause_i = 0; epc_i = 0;
        cp0_we_i = 0; cp0_waddr_i = 0; cp0_wdata_i = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_in(); valid_m = 1; ri_m = 1;
        cycle();
        checks += 3;
        if (except_en_o !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", except_en_o); end
        if ({flush_o, redirect_valid_o} !== 2'b00) begin errors++; $display("FAIL reset_flush got %b exp 00", {flush_o, redirect_valid_o}); end
        if ({except_type_o, redirect_pc_o, inst_addr_o} !== 96'd0) begin errors++; $display("FAIL reset_fields got %h exp 0", {except_type_o, redirect_pc_o, inst_addr_o}); end
        rst = 0; clear_in();
        cycle();
        checks++;
        if (except_en_o !== 1'b0) begin errors++; $display("FAIL idle_en got %b exp 0", except_en_o); end
    endtask

    task automatic test_ri();
        clear_in(); valid_m = 1; ri_m = 1; pc_m = 32'h8000_0100;
        cycle();
        clear_in();
        checks += 4;
        if ({except_en_o, flush_o, redirect_valid_o} !== 3'b111) begin errors++; $display("FAIL ri_ctrl got %b exp 111", {except_en_o, flush_o, redirect_valid_o}); end
        if (except_type_o !== 32'd10) begin errors++; $display("FAIL ri_type got %0d exp 10", except_type_o); end
        if (inst_addr_o !== 32'h8000_0100 || delayslot_o !== 1'b0) begin errors++; $display("FAIL ri_addr got %h/%b exp 80000100/0", inst_addr_o, delayslot_o); end
        if (redirect_pc_o !== VEC || badvaddr_o !== 32'd0) begin errors++; $display("FAIL ri_pc got %h/%h exp %h/0", redirect_pc_o, badvaddr_o, VEC); end
        cycle();
        checks++;
        if ({except_en_o, flush_o, redirect_valid_o, except_type_o, redirect_pc_o} !== 67'd0) begin
            errors++; $display("FAIL ri_after got %b%b%b %h %h exp all 0", except_en_o, flush_o, redirect_valid_o, except_type_o, redirect_pc_o);
        end
    endtask

    task automatic test_priority();
        clear_in(); valid_m = 1; ov_m = 1; ades_d_m = 1; data_addr_m = 32'h1003;
        cycle(); clear_in();
        checks++;
        if (except_type_o !== 32'd12 || badvaddr_o !== 32'd0) begin errors++; $display("FAIL ov_ades got %0d/%h exp 12/0", except_type_o, badvaddr_o); end
        cycle();
        valid_m = 1; ades_d_m = 1; data_addr_m = 32'h1003; delayslot_m = 1;
        cycle(); clear_in();
        checks++;
        if (except_type_o !== 32'd5 || badvaddr_o !== 32'h1003 || delayslot_o !== 1'b1) begin errors++; $display("FAIL ades got %0d/%h/%b exp 5/1003/1", except_type_o, badvaddr_o, delayslot_o); end
        cycle();
        valid_m = 1; adel_if_m = 1; ri_m = 1; adel_d_m = 1; pc_m = 32'h8000_0002; data_addr_m = 32'h55;
        cycle(); clear_in();
        checks++;
        if (except_type_o !== 32'd4 || badvaddr_o !== 32'h8000_0002) begin errors++; $display("FAIL adel_if got %0d/%h exp 4/80000002", except_type_o, badvaddr_o); end
        cycle();
        valid_m = 0; sys_m = 1;
        cycle(); clear_in();
        checks++;
        if (except_en_o !== 1'b0) begin errors++; $display("FAIL bubble got %b exp 0", except_en_o); end
    endtask

    task automatic test_int();
        clear_in(); valid_m = 1; status_i = 32'h0000_0401; ext_int = 6'b000001; pc_m = 32'h8000_0040;
        for (int k = 1; k <= S + 1; k++) begin
            cycle();
            checks++;
            if (except_en_o !== (k == S + 1)) begin errors++; $display("FAIL int_lat k=%0d got %b exp %b", k, except_en_o, k == S + 1); end
        end
        checks++;
        if (except_type_o !== 32'd1 || inst_addr_o !== 32'h8000_0040) begin errors++; $display("FAIL int_type got %0d/%h exp 1/80000040", except_type_o, inst_addr_o); end
        valid_m = 0; ext_int = 0;
        repeat (S + 2) cycle();
        valid_m = 1; ext_int = 6'b000001; cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0000_0400;
        for (int k = 1; k <= S + 3; k++) begin
            cycle();
            checks++;
            if (except_en_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL int_suppress k=%0d got %b%b exp 00", k, except_en_o, flush_o); end
        end
        valid_m = 0; ext_int = 0;
        repeat (S + 2) cycle();
        clear_in(); cycle();
    endtask

    task automatic test_eret();
        clear_in(); valid_m = 1; eret_m = 1; epc_i = 32'h8000_0200;
        cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h8000_0300;
        cycle(); clear_in();
        checks++;
        if (redirect_pc_o !== 32'h8000_0300 || except_type_o !== 32'd14 || except_en_o !== 1'b1) begin
            errors++; $display("FAIL eret got %h/%0d/%b exp 80000300/14/1", redirect_pc_o, except_type_o, except_en_o);
        end
        cycle();
    endtask

    task automatic test_stall();
        clear_in(); valid_m = 1; sys_m = 1; pc_m = 32'h8000_0010;
        cycle(); clear_in(); stall_i = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({except_en_o, flush_o, redirect_valid_o} !== {i == 0, 2'b11} || except_type_o !== 32'd8 || redirect_pc_o !== VEC) begin
                errors++; $display("FAIL stall i=%0d got %b%b%b/%0d exp %b11/8", i, except_en_o, flush_o, redirect_valid_o, except_type_o, i == 0);
            end
            if (i == 3) stall_i = 0;
            cycle();
        end
        checks++;
        if ({except_en_o, flush_o, redirect_valid_o} !== 3'b000) begin errors++; $display("FAIL stall_end got %b exp 000", {except_en_o, flush_o, redirect_valid_o}); end
    endtask

    task automatic test_rst_hold();
        clear_in(); valid_m = 1; bp_m = 1;
        cycle(); clear_in(); stall_i = 1;
        cycle();
        checks++;
        if ({except_en_o, flush_o, except_type_o} !== {2'b01, 32'd9}) begin errors++; $display("FAIL hold got %b%b/%0d exp 01/9", except_en_o, flush_o, except_type_o); end
        rst = 1;
        cycle();
        checks++;
        if ({except_en_o, flush_o, redirect_valid_o, except_type_o, redirect_pc_o} !== 67'd0) begin errors++; $display("FAIL rst_hold got %b%b%b/%h exp 0", except_en_o, flush_o, redirect_valid_o, except_type_o); end
        rst = 0; stall_i = 0; valid_m = 1; ri_m = 1; pc_m = 32'h8000_0500;
        cycle(); clear_in();
        checks++;
        if (except_en_o !== 1'b1 || except_type_o !== 32'd10 || inst_addr_o !== 32'h8000_0500) begin errors++; $display("FAIL rst_then_ri got %b/%0d/%h exp 1/10/80000500", except_en_o, except_type_o, inst_addr_o); end
        cycle();
    endtask

    task automatic test_random();
        logic [5:0]  hist[$];
        int          mode, idx;
        logic [31:0] e_type, e_pc, e_badv, e_rpc, st, ep;
        logic        e_ds, pend, ipb;
        logic [1:0]  cip;
        logic        fl[9];
        int          codes[9] = '{1, 4, 10, 8, 9, 12, 4, 5, 14};
        mode = 0; e_type = 0; e_pc = 0; e_badv = 0; e_rpc = 0; e_ds = 0;
        rst = 1; clear_in(); cycle(); rst = 0;
        repeat (S) hist.push_back(6'd0);
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(39, 0) == 0);
            valid_m = ($urandom_range(4, 0) != 0);
            pc_m = $urandom; data_addr_m = $urandom; delayslot_m = $urandom_range(1, 0) == 1;
            adel_if_m = $urandom_range(11, 0) == 0; ri_m = $urandom_range(11, 0) == 0;
            sys_m = $urandom_range(11, 0) == 0; bp_m = $urandom_range(11, 0) == 0;
            ov_m = $urandom_range(11, 0) == 0; adel_d_m = $urandom_range(11, 0) == 0;
            ades_d_m = $urandom_range(11, 0) == 0; eret_m = $urandom_range(11, 0) == 0;
            status_i = {16'h0, 8'($urandom_range(255, 0)), 6'h0, $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1};
            cause_i = $urandom; epc_i = $urandom;
            cp0_we_i = $urandom_range(2, 0) == 0; cp0_waddr_i = 5'($urandom_range(15, 11)); cp0_wdata_i = $urandom;
            ext_int = ($urandom_range(3, 0) == 0) ? 6'($urandom) : 6'd0;
            stall_i = $urandom_range(3, 0) == 0;
            if (rst) begin
                mode = 0; hist = {};
                repeat (S) hist.push_back(6'd0);
            end else begin
                if (mode == 0) begin
                    st  = (cp0_we_i && cp0_waddr_i == 13'd12) ? cp0_wdata_i : status_i;
                    ep  = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
                    cip = (cp0_we_i && cp0_waddr_i == 5'd13) ? cp0_wdata_i[9:8] : cause_i[9:8];
                    pend = 0;
                    for (int b = 0; b < 8; b++) begin
                        ipb = (b < 2) ? cip[b] : hist[0][b-2];
                        if (ipb && st[8+b]) pend = 1;
                    end
                    fl = '{st[0] && !st[1] && pend, adel_if_m, ri_m, sys_m, bp_m, ov_m, adel_d_m, ades_d_m, eret_m};
                    idx = -1;
                    for (int j = 8; j >= 0; j--) if (fl[j]) idx = j;
                    if (valid_m && idx >= 0) begin
                        mode = 1; e_type = codes[idx]; e_pc = pc_m; e_ds = delayslot_m;
                        e_badv = (idx == 1) ? pc_m : (idx == 6 || idx == 7) ? data_addr_m : 32'd0;
                        e_rpc = (idx == 8) ? ep : VEC;
                    end
                end else begin
                    mode = stall_i ? 2 : 0;
                end
                hist.push_back(ext_int);
                void'(hist.pop_front());
            end
            cycle();
            checks += 2;
            if ({except_en_o, flush_o, redirect_valid_o} !== {mode == 1, mode != 0, mode != 0}) begin
                errors++; $display("FAIL rand_ctrl n=%0d got %b%b%b exp mode %0d", n, except_en_o, flush_o, redirect_valid_o, mode);
            end
            if (mode == 0 ? {except_type_o, inst_addr_o, delayslot_o, badvaddr_o, redirect_pc_o} !== 129'd0
                          : {except_type_o, inst_addr_o, delayslot_o, badvaddr_o, redirect_pc_o} !== {e_type, e_pc, e_ds, e_badv, e_rpc}) begin
                errors++; $display("FAIL rand_fields n=%0d got %0d %h %b %h %h exp %0d %h %b %h %h (mode %0d)", n,
                    except_type_o, inst_addr_o, delayslot_o, badvaddr_o, redirect_pc_o, e_type, e_pc, e_ds, e_badv, e_rpc, mode);
            end
        end
        rst = 0; clear_in(); cycle();
    endtask

    initial begin
        clear_in();
        repeat (2) cycle();
        test_reset();
        test_ri();
        test_priority();
        test_int();
        test_eret();
        test_stall();
        test_rst_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
